// File: rtl/spi_slave.sv
// LSB-first SPI slave, all four modes, clocked only by the master's SCLK (both edges).
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: release MISO to 'z while deselected instead of driving 0.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              slaveSCLK,
    input  logic              reset,
    input  logic              slaveCPOL,
    input  logic              slaveCPHA,
    input  logic              slaveCS_,
    input  logic              slave_start,
    input  logic              slaveMOSI,
    input  logic [DATA_W-1:0] In_Data,
    output logic              slaveMISO,
    output logic [DATA_W-1:0] read_data
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Rising edge of this clock is always the sample edge, falling edge the shift edge.
    // The mode may only change while idle, so the resulting glitch is harmless.
    logic              sample_clk_s;
    logic              active_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] rx_r;
    logic [DATA_W-1:0] rx_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [DATA_W-1:0] read_data_r;
    logic [DATA_W-1:0] read_data_next_s;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] tx_next_s;
    logic              miso_r;
    logic              miso_next_s;

    assign sample_clk_s = slaveSCLK ^ (slaveCPOL ^ slaveCPHA);
    assign active_s     = ~slaveCS_ & slave_start;
    assign shifted_s    = {slaveMOSI, rx_r[DATA_W-1:1]};

    // Sample-edge next state: shift MOSI in, count bits, publish the byte on the last bit.
    always_comb begin
        rx_next_s        = rx_r;
        cnt_next_s       = cnt_r;
        read_data_next_s = read_data_r;
        if (active_s) begin
            rx_next_s = shifted_s;
            if (cnt_r == LAST_BIT) begin
                cnt_next_s       = CNT_ZERO;
                read_data_next_s = shifted_s;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = CNT_ZERO;
        end
    end

    // Sample-edge registers with synchronous reset.
    always_ff @(posedge sample_clk_s) begin
        if (reset) begin
            rx_r        <= {DATA_W{1'b0}};
            cnt_r       <= CNT_ZERO;
            read_data_r <= {DATA_W{1'b0}};
        end else begin
            rx_r        <= rx_next_s;
            cnt_r       <= cnt_next_s;
            read_data_r <= read_data_next_s;
        end
    end

    // Shift-edge next state: a zero count means a new byte starts, so the tx byte is (re)loaded.
    always_comb begin
        tx_next_s   = tx_r;
        miso_next_s = miso_r;
        if (!active_s || (cnt_r == CNT_ZERO)) begin
            tx_next_s   = In_Data;
            miso_next_s = In_Data[0];
        end else begin
            tx_next_s   = tx_r;
            miso_next_s = tx_r[cnt_r];
        end
    end

    // Shift-edge registers with synchronous reset.
    always_ff @(negedge sample_clk_s) begin
        if (reset) begin
            tx_r   <= In_Data;
            miso_r <= In_Data[0];
        end else begin
            tx_r   <= tx_next_s;
            miso_r <= miso_next_s;
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign slaveMISO = slaveCS_ ? 1'bz : miso_r;
`else
    assign slaveMISO = slaveCS_ ? 1'b0 : miso_r;
`endif

    assign read_data = read_data_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a driver acts as SPI master and queues expectations,
// a monitor compares them when the driver announces that the DUT result is presentable.
module tb_spi_slave;

    logic       slaveSCLK;
    logic       reset;
    logic       slaveCPOL;
    logic       slaveCPHA;
    logic       slaveCS_;
    logic       slave_start;
    logic       slaveMOSI;
    logic [7:0] In_Data;
    logic       slaveMISO;
    logic [7:0] read_data;

    spi_slave #(.DATA_W(8)) dut (
        .slaveSCLK  (slaveSCLK),
        .reset      (reset),
        .slaveCPOL  (slaveCPOL),
        .slaveCPHA  (slaveCPHA),
        .slaveCS_   (slaveCS_),
        .slave_start(slave_start),
        .slaveMOSI  (slaveMOSI),
        .In_Data    (In_Data),
        .slaveMISO  (slaveMISO),
        .read_data  (read_data)
    );

    // kind 0: read_data, 1: byte collected by the master, 2: slaveMISO pin
    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    int         present_cnt = 0;
    int         handled     = 0;
    int         n_vec       = 0;
    int         n_err       = 0;
    bit         drv_done    = 1'b0;
    logic [7:0] obs_mb;
    logic [7:0] model_rd;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic [7:0] IDLE_MISO = {7'b0000000, 1'bz};
`else
    localparam logic [7:0] IDLE_MISO = 8'h00;
`endif

    task automatic push(input string nm, input int k, input logic [7:0] e);
        exp_t it;
        it.name = nm;
        it.kind = k;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic present(input int n);
        present_cnt += n;
        #2;
    endtask

    task automatic set_mode(input logic cp, input logic ch);
        slaveCS_  = 1'b1;
        slaveCPOL = cp;
        slaveCPHA = ch;
        slaveSCLK = cp;
        #2;
    endtask

    task automatic idle_cycle();
        slaveCS_ = 1'b1;
        push("miso_idle", 2, IDLE_MISO);
        slaveSCLK = ~slaveCPOL;
        #2;
        slaveSCLK = slaveCPOL;
        #2;
        present(1);
    endtask

    // Master side: MOSI LSB first, MISO captured at the master's sample point.
    task automatic spi_bits(input logic [7:0] mo, input int nb, input int chg_bit,
                            input logic [7:0] chg_val, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (i == chg_bit) In_Data = chg_val;
            if (!slaveCPHA) begin
                slaveMOSI = mo[i];
                #1;
                mi[i] = slaveMISO;
                #1;
                slaveSCLK = ~slaveCPOL;
                #2;
                slaveSCLK = slaveCPOL;
            end else begin
                slaveSCLK = ~slaveCPOL;
                #1;
                slaveMOSI = mo[i];
                #1;
                mi[i] = slaveMISO;
                slaveSCLK = slaveCPOL;
                #2;
            end
        end
        #2;
    endtask

    task automatic full_byte(input string nm, input logic [7:0] ind, input logic [7:0] mo);
        logic [7:0] mb;
        In_Data = ind;
        idle_cycle();
        slaveCS_    = 1'b0;
        slave_start = 1'b1;
        push({nm, "_rd"}, 0, mo);
        push({nm, "_master"}, 1, ind);
        model_rd = mo;
        spi_bits(mo, 8, -1, 8'h00, mb);
        obs_mb = mb;
        present(2);
        slaveCS_ = 1'b1;
    endtask

    task automatic driver();
        logic [7:0] mb;
        logic [7:0] ind;
        logic [7:0] mo;
        int         nb;
        int         md;
        slaveSCLK   = 1'b0;
        slaveCPOL   = 1'b0;
        slaveCPHA   = 1'b0;
        slaveCS_    = 1'b1;
        slave_start = 1'b0;
        slaveMOSI   = 1'b0;
        reset       = 1'b1;
        In_Data     = 8'h0F;
        #2 slaveSCLK = 1'b1;
        #2 slaveSCLK = 1'b0;
        push("reset_rd", 0, 8'h00);
        model_rd = 8'h00;
        present(1);
        reset = 1'b0;

        full_byte("mode0", 8'h0F, 8'hAA);

        // Abort after 4 bits: read_data must keep its previous value.
        In_Data = 8'h3C;
        idle_cycle();
        slaveCS_    = 1'b0;
        slave_start = 1'b1;
        push("abort_rd", 0, model_rd);
        spi_bits(8'h3C, 4, -1, 8'h00, mb);
        present(1);
        slaveCS_ = 1'b1;
        full_byte("after_abort", 8'hC3, 8'h3C);

        set_mode(1'b0, 1'b1);
        full_byte("mode1", 8'hD8, 8'h76);
        set_mode(1'b1, 1'b0);
        full_byte("mode2", 8'h59, 8'h00);
        set_mode(1'b1, 1'b1);
        full_byte("mode3", 8'h1B, 8'hFF);

        // Chip selected but transfer not enabled: nothing is received.
        set_mode(1'b0, 1'b0);
        In_Data = 8'h66;
        idle_cycle();
        slaveCS_    = 1'b0;
        slave_start = 1'b0;
        push("nostart_rd", 0, model_rd);
        spi_bits(8'h99, 8, -1, 8'h00, mb);
        present(1);
        slaveCS_    = 1'b1;
        slave_start = 1'b1;

        // Reset in the middle of a byte, with CS_ still low.
        In_Data = 8'h35;
        idle_cycle();
        slaveCS_ = 1'b0;
        spi_bits(8'h3C, 4, -1, 8'h00, mb);
        reset = 1'b1;
        push("midreset_rd", 0, 8'h00);
        push("midreset_miso", 2, {7'b0000000, In_Data[0]});
        model_rd = 8'h00;
        slaveSCLK = ~slaveCPOL;
        #2;
        slaveSCLK = slaveCPOL;
        #2;
        present(2);
        reset    = 1'b0;
        slaveCS_ = 1'b1;
        idle_cycle();

        // Two bytes without releasing CS_; In_Data changes during the first.
        In_Data = 8'hA5;
        idle_cycle();
        slaveCS_ = 1'b0;
        push("b2b1_rd", 0, 8'h81);
        push("b2b1_master", 1, 8'hA5);
        spi_bits(8'h81, 8, 3, 8'h42, mb);
        obs_mb = mb;
        present(2);
        push("b2b2_rd", 0, 8'h7E);
        push("b2b2_master", 1, 8'h42);
        spi_bits(8'h7E, 8, -1, 8'h00, mb);
        obs_mb = mb;
        present(2);
        model_rd = 8'h7E;
        slaveCS_ = 1'b1;
        idle_cycle();

        // Random modes, data and occasional aborted bytes.
        for (int r = 0; r < 24; r++) begin
            md  = $urandom_range(0, 3);
            ind = 8'($urandom);
            mo  = 8'($urandom);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            set_mode(md[1], md[0]);
            In_Data = ind;
            idle_cycle();
            slaveCS_ = 1'b0;
            if (nb == 8) begin
                model_rd = mo;
                push("rand_rd", 0, model_rd);
                push("rand_master", 1, ind);
            end else begin
                push("rand_abort_rd", 0, model_rd);
            end
            spi_bits(mo, nb, -1, 8'h00, mb);
            obs_mb = mb;
            present((nb == 8) ? 2 : 1);
            slaveCS_ = 1'b1;
        end
        idle_cycle();
        #4;
    endtask

    task automatic monitor();
        exp_t       e;
        logic [7:0] act;
        int         w;
        forever begin
            w = 0;
            while (present_cnt == handled && !drv_done && w < 2000) begin
                #1;
                w++;
            end
            if (present_cnt == handled) begin
                if (!drv_done) begin
                    $display("FAIL monitor_timeout: got no result, expected one within 2000 time units");
                    n_err++;
                end
                break;
            end
            #1;
            while (handled < present_cnt) begin
                handled++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_empty: got a result, expected an entry in the queue");
                    n_err++;
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        0:       act = read_data;
                        1:       act = obs_mb;
                        default: act = {7'b0000000, slaveMISO};
                    endcase
                    n_vec++;
                    if (act !== e.exp) begin
                        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                        n_err++;
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            begin
                driver();
                drv_done = 1'b1;
            end
            monitor();
        join
        if (exp_q.size() != 0) begin
            $display("FAIL leftover_expectations: got %0d unchecked, expected 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
